// File: rtl/dot_product_tree.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : dot_product_tree                                           |
// | Description : Signed-selection dot-product reducer. Each lane adds or   |
// |               subtracts its unsigned coefficient; lanes are summed by a  |
// |               binary adder tree with optional per-level pipelining.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module dot_product_tree #(
    parameter int                           VECTOR_SIZE     = 256,
    parameter int                           J_ELEMENT_WIDTH = 4,
    parameter bit                           PIPED           = 1'b0,
    parameter logic [$clog2(VECTOR_SIZE):0] PIPE_STAGE_MASK = '1,
    localparam int                          LEVELS           = $clog2(VECTOR_SIZE),
    localparam int                          INT_RESULT_WIDTH = J_ELEMENT_WIDTH + LEVELS + 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [VECTOR_SIZE-1:0]             sigma,
    input  logic [J_ELEMENT_WIDTH-1:0]         J_col [0:VECTOR_SIZE-1],
    input  logic                               start,
    output logic signed [INT_RESULT_WIDTH-1:0] dot_out,
    output logic                               start_out
);

    localparam int C_W          = INT_RESULT_WIDTH;
    localparam int C_REG_LEVELS = PIPED ? $countones(PIPE_STAGE_MASK) : 0;

    // Level k holds 2^(LEVELS-k) nodes; level LEVELS is the single root.
    for (genvar k = 0; k <= LEVELS; k++) begin : g_level
        localparam int  C_NUM    = 1 << (LEVELS - k);
        localparam bit  C_IS_REG = PIPED && PIPE_STAGE_MASK[k];

        logic signed [C_W-1:0] lvl [0:C_NUM-1];
        logic                  stage_start;

        for (genvar j = 0; j < C_NUM; j++) begin : g_node
            logic signed [C_W-1:0] node_d;

            if (k == 0) begin : g_leaf
                if (j < VECTOR_SIZE) begin : g_lane
                    logic signed [C_W-1:0] w_mag;
                    always_comb begin
                        w_mag  = {{(C_W - J_ELEMENT_WIDTH){1'b0}}, J_col[j]};
                        node_d = sigma[j] ? w_mag : -w_mag;
                    end
                end else begin : g_pad
                    always_comb begin
                        node_d = '0;
                    end
                end
            end else begin : g_sum
                always_comb begin
                    node_d = g_level[k-1].lvl[2*j] + g_level[k-1].lvl[2*j+1];
                end
            end

            if (C_IS_REG) begin : g_reg
                logic signed [C_W-1:0] node_q;
                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        node_q <= '0;
                    end else begin
                        node_q <= node_d;
                    end
                end
                assign lvl[j] = node_q;
            end else begin : g_comb
                assign lvl[j] = node_d;
            end
        end

        // The start token follows the same register placement as the data.
        logic start_d;
        if (k == 0) begin : g_start_in
            always_comb begin
                start_d = start;
            end
        end else begin : g_start_chain
            always_comb begin
                start_d = g_level[k-1].stage_start;
            end
        end

        if (C_IS_REG) begin : g_start_reg
            logic start_q;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    start_q <= 1'b0;
                end else begin
                    start_q <= start_d;
                end
            end
            assign stage_start = start_q;
        end else begin : g_start_comb
            assign stage_start = start_d;
        end
    end

    assign dot_out   = g_level[LEVELS].lvl[0];
    assign start_out = g_level[LEVELS].stage_start;

    // A fully combinational build has no state, so clock and reset go unread.
    if (C_REG_LEVELS == 0) begin : g_no_state
        logic unused_clk_rst;
        assign unused_clk_rst = &{1'b0, clk, rst_n};
    end

endmodule
`default_nettype wire

// File: tb/tb_dot_product_tree.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_dot_product_tree                                        |
// | Description : Scoreboard bench for combinational, fully piped and        |
// |               sparsely piped builds of dot_product_tree.                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_dot_product_tree;

    localparam int         C_VS       = 256;
    localparam int         C_JW       = 4;
    localparam int         C_RW       = 13;
    localparam logic [8:0] C_MASK_SPR = 9'b0_0010_0010;
    localparam int         C_L_FULL   = 9;
    localparam int         C_L_SPR    = 2;

    typedef struct {
        logic signed [C_RW-1:0] dot;
        logic                   st;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [C_VS-1:0]        sigma;
    logic [C_JW-1:0]        j_col [0:C_VS-1];
    logic                   start;
    logic signed [C_RW-1:0] dot_comb, dot_full, dot_spr;
    logic                   so_comb, so_full, so_spr;

    exp_t q_full[$];
    exp_t q_spr[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    dot_product_tree #(.VECTOR_SIZE(C_VS), .J_ELEMENT_WIDTH(C_JW), .PIPED(1'b0)) u_comb (
        .clk(clk), .rst_n(rst_n), .sigma(sigma), .J_col(j_col), .start(start),
        .dot_out(dot_comb), .start_out(so_comb)
    );

    dot_product_tree #(.VECTOR_SIZE(C_VS), .J_ELEMENT_WIDTH(C_JW), .PIPED(1'b1)) u_full (
        .clk(clk), .rst_n(rst_n), .sigma(sigma), .J_col(j_col), .start(start),
        .dot_out(dot_full), .start_out(so_full)
    );

    dot_product_tree #(.VECTOR_SIZE(C_VS), .J_ELEMENT_WIDTH(C_JW), .PIPED(1'b1),
                       .PIPE_STAGE_MASK(C_MASK_SPR)) u_spr (
        .clk(clk), .rst_n(rst_n), .sigma(sigma), .J_col(j_col), .start(start),
        .dot_out(dot_spr), .start_out(so_spr)
    );

    function automatic logic signed [C_RW-1:0] model();
        int s = 0;
        for (int i = 0; i < C_VS; i++) begin
            s += sigma[i] ? int'(j_col[i]) : -int'(j_col[i]);
        end
        return C_RW'(s);
    endfunction

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic rand_inputs();
        for (int i = 0; i < C_VS; i++) begin
            j_col[i] = C_JW'($urandom_range(0, 15));
        end
        for (int w = 0; w < C_VS / 32; w++) begin
            sigma[w*32 +: 32] = $urandom();
        end
        start = 1'($urandom_range(0, 1));
    endtask

    // One clock cycle: check the combinational build, enqueue the expectation,
    // clock, then retire the oldest due expectation of each piped build.
    task automatic step(input bit use_lit, input int lit);
        exp_t e;
        exp_t f;
        e.dot = use_lit ? C_RW'(lit) : model();
        e.st  = start;
        #1;
        check("comb_dot", dot_comb, e.dot);
        check("comb_start", {31'd0, so_comb}, {31'd0, e.st});
        q_full.push_back(e);
        q_spr.push_back(e);
        @(posedge clk);
        #1;
        if (q_full.size() >= C_L_FULL) begin
            f = q_full.pop_front();
            check("full_dot", dot_full, f.dot);
            check("full_start", {31'd0, so_full}, {31'd0, f.st});
        end
        if (q_spr.size() >= C_L_SPR) begin
            f = q_spr.pop_front();
            check("sparse_dot", dot_spr, f.dot);
            check("sparse_start", {31'd0, so_spr}, {31'd0, f.st});
        end
    endtask

    // Reset with start asserted; in-flight work is dropped and the piped
    // outputs read zero until the first post-reset set has propagated.
    task automatic do_reset(input int cycles);
        exp_t z;
        z.dot = '0;
        z.st  = 1'b0;
        rst_n = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            rand_inputs();
            start = 1'b1;
            #1;
            check("rst_comb_dot", dot_comb, model());
            @(posedge clk);
            #1;
            check("rst_full_dot", dot_full, 0);
            check("rst_full_start", {31'd0, so_full}, 0);
            check("rst_sparse_dot", dot_spr, 0);
            check("rst_sparse_start", {31'd0, so_spr}, 0);
        end
        q_full.delete();
        q_spr.delete();
        for (int i = 0; i < C_L_FULL - 1; i++) q_full.push_back(z);
        for (int i = 0; i < C_L_SPR - 1; i++) q_spr.push_back(z);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        sigma = '0;
        start = 1'b0;
        for (int i = 0; i < C_VS; i++) j_col[i] = '0;

        do_reset(3);

        for (int i = 0; i < C_VS; i++) j_col[i] = C_JW'(i % 16);
        sigma = '1;
        start = 1'b1;
        step(1'b1, 1920);

        sigma = '0;
        start = 1'b0;
        step(1'b1, -1920);

        for (int i = 0; i < C_VS; i++) sigma[i] = i[0];
        start = 1'b1;
        step(1'b1, 128);

        for (int i = 0; i < C_VS; i++) j_col[i] = 4'hF;
        sigma = '1;
        start = 1'b0;
        step(1'b1, 3840);

        sigma = '0;
        start = 1'b1;
        step(1'b1, -3840);

        for (int n = 0; n < 16; n++) begin
            rand_inputs();
            step(1'b0, 0);
        end

        for (int n = 0; n < 10; n++) begin
            rand_inputs();
            start = 1'b1;
            step(1'b0, 0);
        end

        do_reset(3);

        for (int n = 0; n < 12; n++) begin
            rand_inputs();
            step(1'b0, 0);
        end

        for (int n = 0; n < 10; n++) begin
            rand_inputs();
            start = 1'b0;
            step(1'b0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dot_product_tree.md
# dot_product_tree

Signed-selection dot-product reducer: for every lane i it adds or subtracts an unsigned coefficient J_col[i] according to a one-bit spin sigma[i], then sums all lanes through a binary adder tree. The tree is purely combinational or optionally pipelined at selectable levels. A start token travels alongside the data with identical latency. It is the column-accumulation kernel that sits between the spin register and the downstream energy/field logic.

## Interface
- PIPED, default 1'b0: 0 = fully combinational tree; 1 = insert registers at levels selected by PIPE_STAGE_MASK.
- PIPE_STAGE_MASK, default all ones, width LEVELS+1: bit k = 1 registers tree level k. Ignored when PIPED=0.
- VECTOR_SIZE, default 256: number of lanes, ≥2.
- J_ELEMENT_WIDTH, default 4: width of each unsigned J element.
- Derived LEVELS = $clog2(VECTOR_SIZE).
- Derived INT_RESULT_WIDTH = J_ELEMENT_WIDTH + LEVELS + 1.

Ports:
- clk  input  1  clock; all registers rise-edge.
- rst_n  input  1  reset, synchronous, active-low.
- sigma  input  VECTOR_SIZE  per-lane sign; 1 = add J_col[i], 0 = subtract J_col[i].
- J_col  input  unpacked [0:VECTOR_SIZE-1] of J_ELEMENT_WIDTH  unsigned coefficients.
- start  input  1  token marking the input set to track.
- dot_out  output  INT_RESULT_WIDTH signed  Σ (sigma[i] ? +J_col[i] : −J_col[i]).
- start_out  output  1  start delayed by the same latency as dot_out.

## Operation
- Level 0 leaves: each J_col[i] is zero-extended to INT_RESULT_WIDTH, never sign-extended. The leaf value is +J when sigma[i]=1 and its two's complement when sigma[i]=0.
- If VECTOR_SIZE is not a power of two, pad the leaves to 2^LEVELS with zero terms.
- Level k (1..LEVELS): pairwise sums of level k−1, giving 2^(LEVELS−k) nodes. Level LEVELS is the final sum.
- All arithmetic is signed at INT_RESULT_WIDTH. The full range ±VECTOR_SIZE·(2^J_ELEMENT_WIDTH−1) fits, so no saturation or overflow handling is needed.
- PIPED=0: dot_out is combinational from sigma/J_col. start_out = start combinationally. No registers exist in the datapath.
- PIPED=1: for each k with PIPE_STAGE_MASK[k]=1, all level-k node values are registered. A parallel start shift register gets one flop per registered level.
- Tree is fully pipelined: throughput is one new input set per cycle, with no stalls and no back-pressure.

## Timing
- Latency L = PIPED ? $countones(PIPE_STAGE_MASK) : 0 clock edges.
- PIPED=1: inputs stable before edge n produce their result on dot_out after edge n+L−1, together with start_out = start at that edge.
- Default mask, 256 lanes: L=9.
- A mask of all zeros with PIPED=1 behaves as combinational, with L=0.
- Reset: when rst_n=0 at a rising edge, every pipeline register, including the start shift register, clears to 0.
    - Consequence: dot_out=0 and start_out=0 after the reset edge, until new data propagates.
    - PIPED=0 has no state; reset has no effect on it.
- Reset mid-operation discards all in-flight results and tokens. No token emerges for inputs captured before the reset edge.
- Inputs may change every cycle; each cycle's input set is processed independently.

## Test plan
Default setup: VECTOR_SIZE=256, J_ELEMENT_WIDTH=4, INT_RESULT_WIDTH=13. Run each case with PIPED=0, and with PIPED=1 on the all-ones mask (L=9), sampling dot_out after L edges.
- J_col[i]=i mod 16, sigma all 1 → dot_out = +1920.
- Same J, sigma all 0 → dot_out = −1920.
- Same J, sigma[i]=i%2 (odd lanes add, even lanes subtract) → dot_out = +128.
- Extremes: J all 15, sigma all 1 → +3840; J all 15, sigma all 0 → −3840. Confirms zero-extension and no overflow.
- Random J/sigma, changed every cycle for ≥5 cycles against a reference model:
    - each result matches its own input set exactly L cycles later;
    - a start pulse at cycle c appears on start_out only at cycle c+L.
- Hold rst_n=0 for 3 edges with the pipeline full, then release:
    - dot_out=0 and start_out=0 immediately after the reset edge;
    - the first valid result appears L edges after the first post-reset input.
